// File: rtl/operand_seq_fsm.sv
// Operand-sequencing controller: captures an opcode, collects one or NUM_OPS register
// selections with per-slot load strobes, fires the ALU and holds the result until acked.
module operand_seq_fsm #(
  parameter int unsigned        REG_W      = 3,
  parameter int unsigned        OP_W       = 3,
  parameter int unsigned        NUM_OPS    = 2,
  parameter logic [2**OP_W-1:0] UNARY_MASK = '0,
  parameter int unsigned        TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               r_en,
  input  logic [OP_W-1:0]    opcode,
  input  logic [REG_W-1:0]   reg_num,
  input  logic               abort,
  input  logic               result_ack,
  output logic [REG_W-1:0]   reg_sel,
  output logic [NUM_OPS-1:0] op_load,
  output logic [OP_W-1:0]    alu_op,
  output logic               alu_en,
  output logic               result_valid,
  output logic               busy,
  output logic               err_timeout
);

  localparam int unsigned IdxW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    StIdle,
    StOpc,
    StSel,
    StLoad,
    StGap,
    StExec,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [REG_W-1:0] reg_sel_q, reg_sel_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  // Index of the final operand slot for the latched opcode (need - 1).
  logic [IdxW-1:0]  last_q, last_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             waiting;
  logic             met;
  logic             timeout_hit;

  always_comb begin
    state_d   = state_q;
    alu_op_d  = alu_op_q;
    reg_sel_d = reg_sel_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = '0;
    err_d     = 1'b0;
    waiting   = 1'b0;
    met       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (r_en && !abort) state_d = StOpc;
      end
      StOpc: begin
        waiting = 1'b1;
        met     = (opcode != '0);
        if (met) begin
          state_d  = StSel;
          alu_op_d = opcode;
          last_d   = UNARY_MASK[opcode] ? '0 : IdxW'(NUM_OPS - 1);
          idx_d    = '0;
        end
      end
      StSel: begin
        waiting = 1'b1;
        met     = (reg_num != '0);
        if (met) begin
          state_d   = StLoad;
          reg_sel_d = reg_num;
        end
      end
      StLoad: begin
        if (idx_q == last_q) begin
          state_d = StExec;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StGap;
        end
      end
      StGap: begin
        waiting = 1'b1;
        // Key must be released before the next selection can be captured.
        met     = (reg_num == '0);
        if (met) state_d = StSel;
      end
      StExec: state_d = StDone;
      StDone: begin
        if (result_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    timeout_hit = (TIMEOUT != 0) && waiting && !met && (cnt_q == CntLast);

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
    end else if (timeout_hit) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end

    if ((TIMEOUT != 0) && waiting && (state_d == state_q)) cnt_d = cnt_q + 1'b1;

    if (state_d == StIdle) begin
      alu_op_d  = '0;
      reg_sel_d = '0;
      idx_d     = '0;
      last_d    = '0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      alu_op_q  <= '0;
      reg_sel_q <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_op_q  <= alu_op_d;
      reg_sel_q <= reg_sel_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    op_load = '0;
    if (state_q == StLoad) op_load[idx_q] = 1'b1;
  end

  assign reg_sel      = reg_sel_q;
  assign alu_op       = alu_op_q;
  assign alu_en       = (state_q == StExec);
  assign result_valid = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_operand_seq_fsm.sv
// Directed and randomized bench for operand_seq_fsm; expectations come from a
// transaction-level model of the operand sequence (slot order, operand count, latency).
module tb_operand_seq_fsm;

  localparam int unsigned REG_W   = 3;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned NUM_OPS = 2;
  localparam logic [7:0]  UNARY   = 8'h10;

  logic clk, rst, r_en, abort, result_ack;
  logic [OP_W-1:0]  opcode;
  logic [REG_W-1:0] reg_num;

  logic [REG_W-1:0]   reg_sel_a, reg_sel_b;
  logic [NUM_OPS-1:0] op_load_a, op_load_b;
  logic [OP_W-1:0]    alu_op_a, alu_op_b;
  logic alu_en_a, result_valid_a, busy_a, err_timeout_a;
  logic alu_en_b, result_valid_b, busy_b, err_timeout_b;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  logic [REG_W-1:0] rv [NUM_OPS];

  operand_seq_fsm #(
    .REG_W(REG_W), .OP_W(OP_W), .NUM_OPS(NUM_OPS), .UNARY_MASK(UNARY), .TIMEOUT(255)
  ) u_dut_a (
    .clk(clk), .rst(rst), .r_en(r_en), .opcode(opcode), .reg_num(reg_num),
    .abort(abort), .result_ack(result_ack), .reg_sel(reg_sel_a), .op_load(op_load_a),
    .alu_op(alu_op_a), .alu_en(alu_en_a), .result_valid(result_valid_a), .busy(busy_a),
    .err_timeout(err_timeout_a)
  );

  operand_seq_fsm #(
    .REG_W(REG_W), .OP_W(OP_W), .NUM_OPS(NUM_OPS), .UNARY_MASK(UNARY), .TIMEOUT(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .r_en(r_en), .opcode(opcode), .reg_num(reg_num),
    .abort(abort), .result_ack(result_ack), .reg_sel(reg_sel_b), .op_load(op_load_b),
    .alu_op(alu_op_b), .alu_en(alu_en_b), .result_valid(result_valid_b), .busy(busy_b),
    .err_timeout(err_timeout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance A; returns cycles from r_en to result_valid.
  task automatic run_op(input logic [OP_W-1:0] op, input logic [REG_W-1:0] regs [NUM_OPS],
                        input int opc_wait, input int sel_wait, input int hold,
                        input int ack_wait, output int latency);
    int need;
    need    = UNARY[op] ? 1 : NUM_OPS;
    latency = 0;
    r_en = 1'b1;
    tick(); latency++;
    r_en = 1'b0;
    chk("busy_rise", busy_a, 1);
    for (int i = 0; i < opc_wait; i++) begin
      tick(); latency++;
      chk("opc_wait_busy", busy_a, 1);
    end
    opcode = op;
    tick(); latency++;
    opcode = 3'($urandom_range(0, 7));
    chk("alu_op_latch", alu_op_a, op);
    for (int k = 0; k < need; k++) begin
      reg_num = '0;
      for (int i = 0; i < sel_wait; i++) begin
        tick(); latency++;
        chk("sel_wait_no_load", op_load_a, 0);
      end
      reg_num = regs[k];
      tick(); latency++;
      chk("load_strobe", op_load_a, 32'd1 << k);
      chk("load_reg_sel", reg_sel_a, regs[k]);
      if (k != need - 1) begin
        for (int h = 0; h < hold; h++) begin
          tick(); latency++;
          chk("gap_no_load", op_load_a, 0);
        end
        reg_num = '0;
        tick(); latency++;
      end
    end
    reg_num = '0;
    tick(); latency++;
    chk("exec_alu_en", {alu_en_a, op_load_a}, 3'b100);
    chk("exec_alu_op", alu_op_a, op);
    tick(); latency++;
    chk("done_valid", {result_valid_a, alu_en_a}, 2'b10);
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      chk("done_hold", result_valid_a, 1);
    end
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    opcode = '0;
    chk("ack_idle", {result_valid_a, busy_a, alu_op_a, reg_sel_a}, 0);
  endtask

  initial begin
    rst = 1'b1; r_en = 1'b0; abort = 1'b0; result_ack = 1'b0;
    opcode = '0; reg_num = '0;
    tick(); tick();
    chk("reset_outputs", {reg_sel_a, op_load_a, alu_op_a, alu_en_a, result_valid_a,
                          busy_a, err_timeout_a}, 0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", busy_a, 0);

    // Binary op 3 with registers 5 then 2, minimum-latency path.
    rv[0] = 3'd5; rv[1] = 3'd2;
    run_op(3'd3, rv, 0, 0, 1, 2, lat);
    chk("min_latency", lat, 8);

    // Unary op 4: only slot 0.
    rv[0] = 3'd6; rv[1] = 3'd0;
    run_op(3'd4, rv, 0, 0, 1, 0, lat);
    chk("unary_latency", lat, 5);

    // Held key for 10 cycles in GAP.
    rv[0] = 3'd5; rv[1] = 3'd5;
    run_op(3'd1, rv, 1, 1, 10, 1, lat);

    // Abort during GAP.
    r_en = 1'b1; tick(); r_en = 1'b0;
    opcode = 3'd2; tick(); opcode = '0;
    reg_num = 3'd3; tick();
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_gap", {busy_a, err_timeout_a, op_load_a, alu_op_a}, 0);
    tick();
    chk("abort_no_err", {err_timeout_a, busy_a}, 0);

    // Abort in SEL while a register is offered: no strobe.
    reg_num = '0;
    r_en = 1'b1; tick(); r_en = 1'b0;
    opcode = 3'd5; tick(); opcode = '0;
    reg_num = 3'd7; abort = 1'b1; tick(); abort = 1'b0; reg_num = '0;
    chk("abort_sel", {busy_a, op_load_a, alu_en_a}, 0);

    // Abort in IDLE blocks r_en.
    r_en = 1'b1; abort = 1'b1; tick(); r_en = 1'b0; abort = 1'b0;
    chk("abort_idle_blocks", busy_a, 0);

    // Reset during LOAD, then a clean restart.
    r_en = 1'b1; tick(); r_en = 1'b0;
    opcode = 3'd3; tick(); opcode = '0;
    reg_num = 3'd5; tick();
    chk("pre_reset_load", op_load_a, 1);
    rst = 1'b1; tick(); rst = 1'b0; reg_num = '0;
    chk("reset_mid", {reg_sel_a, op_load_a, alu_op_a, alu_en_a, result_valid_a,
                      busy_a, err_timeout_a}, 0);
    rv[0] = 3'd1; rv[1] = 3'd7;
    run_op(3'd6, rv, 0, 2, 1, 0, lat);

    // Randomized transactions.
    for (int t = 0; t < 16; t++) begin
      logic [OP_W-1:0] op;
      op = 3'($urandom_range(1, 7));
      for (int k = 0; k < NUM_OPS; k++) rv[k] = 3'($urandom_range(1, 7));
      run_op(op, rv, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4),
             $urandom_range(0, 3), lat);
    end

    // Timeout checks on the TIMEOUT=4 instance.
    rst = 1'b1; tick(); rst = 1'b0;
    r_en = 1'b1; tick(); r_en = 1'b0;
    opcode = 3'd3; tick(); opcode = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sel_wait_b", {busy_b, err_timeout_b}, 2'b10);
    end
    tick();
    chk("sel_timeout", {busy_b, err_timeout_b, alu_en_b}, 3'b010);
    tick();
    chk("timeout_pulse_end", err_timeout_b, 0);

    r_en = 1'b1; tick(); r_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("opc_wait_b", busy_b, 1);
    tick();
    chk("opc_timeout", {busy_b, err_timeout_b}, 2'b01);

    // Input arriving on the last permitted cycle is accepted; then GAP times out.
    r_en = 1'b1; tick(); r_en = 1'b0;
    opcode = 3'd3; tick(); opcode = '0;
    for (int i = 0; i < 3; i++) tick();
    reg_num = 3'd2; tick();
    chk("sel_boundary_load", {op_load_b, err_timeout_b}, 3'b010);
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("gap_wait_b", busy_b, 1);
    tick();
    reg_num = '0;
    chk("gap_timeout", {busy_b, err_timeout_b, alu_en_b}, 3'b010);

    // DONE never times out.
    r_en = 1'b1; tick(); r_en = 1'b0;
    opcode = 3'd4; tick(); opcode = '0;
    reg_num = 3'd1; tick(); reg_num = '0;
    tick();
    chk("b_exec", alu_en_b, 1);
    for (int i = 0; i < 8; i++) tick();
    chk("done_no_timeout", {result_valid_b, err_timeout_b}, 2'b10);
    result_ack = 1'b1; tick(); result_ack = 1'b0;
    chk("b_ack", {result_valid_b, busy_b}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
